sha_mem_arbiter: RTL and testbench
==================================

Name: sha_mem_arbiter

Overview:
- Round-robin arbiter sharing the single-port word SRAM (32-bit data, 16-bit address) among NUM_REQ SHA-256 / bitcoin hash cores.
- Sits between the cores' memory interfaces (we/addr/write_data/read_data) and the one physical memory port.
- Provides per-requester grant and read-valid handshakes so each core can stall while another owns the port.

Parameters:
- NUM_REQ, 4, number of requesting cores (2..16).
- REQ_W, $clog2(NUM_REQ), width of the requester index / round-robin pointer.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous, active-low reset.
- req  in  NUM_REQ  per-core access request; held until granted.
- req_we  in  NUM_REQ  per-core write enable; 1 = write, 0 = read.
- req_addr  in  NUM_REQ*16  packed per-core word addresses; core i uses bits [16i+15:16i].
- req_wdata  in  NUM_REQ*32  packed per-core write data.
- req_lock  in  NUM_REQ  per-core burst lock; used only with SHA_ARB_LOCK_EN.
- gnt  out  NUM_REQ  one-hot grant; the access is accepted in this cycle.
- rvalid  out  NUM_REQ  one-hot; rdata is valid for that core in this cycle.
- rdata  out  32  read data, broadcast to all cores.
- mem_clk  out  1  equals clk.
- mem_we  out  1  memory write enable.
- mem_addr  out  16  memory address.
- mem_write_data  out  32  memory write data.
- mem_read_data  in  32  memory read data; valid one cycle after a read address is presented.
- busy_cycles  out  32  count of cycles in which gnt != 0.

Behaviour:
- Reset, while reset_n=0 at a posedge:
  - rr_ptr=0, rvalid=0, rd_pending=0, busy_cycles=0, lock_owner cleared.
  - gnt=0, mem_we=0, mem_addr=0, mem_write_data=0, regardless of req.
- Arbitration (combinational, same cycle):
  - Winner = first i with req[i]=1, searching rr_ptr, rr_ptr+1, … modulo NUM_REQ.
  - gnt[winner]=1.
  - mem_we, mem_addr, mem_write_data are muxed from the winner.
  - No request: gnt=0, mem_we=0, mem_addr/mem_write_data hold their last granted values.
- Pointer update: on any grant, rr_ptr <= winner+1; it wraps from NUM_REQ-1 to 0.
- Accepted access: req[i]=1 and gnt[i]=1 at a posedge.
  - The core must drop or change its request the following cycle; otherwise it competes again.
- Read return:
  - A granted read sets rd_pending <= 1 and rd_id <= winner.
  - Next cycle: rvalid[rd_id]=1 and rdata=mem_read_data.
  - Reads are pipelined, so back-to-back reads from different cores give one rvalid per cycle, in grant order.
- Writes produce no rvalid.
- A write granted in the same cycle as a pending read's rvalid is legal; both complete.
- Starvation bound: a continuously requesting core is granted within NUM_REQ cycles.
- busy_cycles increments on every cycle with any grant and saturates at 32'hFFFF_FFFF.
- Reset asserted mid-operation: any in-flight read is dropped and no rvalid is issued for it.

Optional Feature:
- Macro: SHA_ARB_LOCK_EN.
- Enabled:
  - A grant issued while req_lock[winner]=1 records lock_owner=winner.
  - While lock_owner is valid and req[lock_owner]=1, only lock_owner is granted each cycle and rr_ptr does not advance.
  - The lock releases on the first cycle req_lock[lock_owner]=0 or req[lock_owner]=0. Arbitration resumes that same cycle, with rr_ptr = lock_owner+1.
  - Intended use: 16-word block fetch with no interleaving.
- Disabled: req_lock is ignored and no lock state is synthesized.

Decomposition:
- Package sha_arb_pkg:
  - ADDR_W=16, DATA_W=32.
  - typedef mem_req_t {we, addr, wdata}.
  - function rr_pick(req, ptr) returning winner index and valid.
- Sub-module rr_arbiter: pure round-robin picker plus rr_ptr register, parameterized NUM_REQ, reused by later nonce dispatchers.

Test Plan:
1. Single requester: core0 reads addr 16'd5 holding 32'hDEADBEEF. gnt[0] is high the same cycle; next cycle rvalid[0]=1 and rdata=32'hDEADBEEF.
2. All four cores request continuously after reset. Grants rotate 0,1,2,3,0…; each core is granted exactly once per 4 cycles; busy_cycles=8 after 8 cycles.
3. Interleaved: core1 writes 32'h01234765 to 16'd1000, then core2 reads 16'd1000 the next cycle. rvalid[2]=1 with rdata=32'h01234765.
4. Back-to-back reads from cores 3 then 0 (rr_ptr=3) of addrs 16'd20/16'd21. rvalid[3] then rvalid[0] on consecutive cycles with the correct data.
5. SHA_ARB_LOCK_EN: core1 holds req_lock for 16 reads while cores 0/2 request. Cores 0/2 get no grant during those 16 cycles; core2 is granted on the cycle the lock drops.
6. Reset after a granted read with rvalid still pending. No rvalid fires; all outputs are at reset values; the first grant after reset goes to core0.

Source files
------------

// File: rtl/sha_arb_pkg.sv
// Shared types and helpers for the SHA core memory arbiter and for
// other round-robin dispatchers built on the same picker.
package sha_arb_pkg;

    localparam int ADDR_W    = 16;
    localparam int DATA_W    = 32;
    localparam int MAX_REQ   = 16;
    localparam int REQ_IDX_W = 4;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_req_t;

    typedef struct packed {
        logic                 valid;
        logic [REQ_IDX_W-1:0] idx;
    } rr_pick_t;

    // First requester at or after ptr, wrapping modulo num_req.
    function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0]   req,
                                         input logic [REQ_IDX_W-1:0] ptr,
                                         input int unsigned          num_req);
        rr_pick_t             res;
        logic [REQ_IDX_W-1:0] cand;
        res = '0;
        for (int unsigned k = 0; k < MAX_REQ; k++) begin
            cand = REQ_IDX_W'((32'(ptr) + k) % num_req);
            if (k < num_req && !res.valid && req[cand]) begin
                res.valid = 1'b1;
                res.idx   = cand;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker with its rotating priority pointer. The pointer moves
// to just past the winner whenever a grant is taken and upd_en allows it.
module rr_arbiter
    import sha_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int REQ_W   = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               upd_en,
    output logic               gnt_vld,
    output logic [REQ_W-1:0]   gnt_idx
);

    logic [REQ_W-1:0] rr_ptr;
    rr_pick_t         pick;

    // Combinational search starting at the current pointer.
    always_comb begin
        pick = rr_pick(MAX_REQ'(req), REQ_IDX_W'(rr_ptr), NUM_REQ);
    end

    assign gnt_vld = pick.valid;
    assign gnt_idx = REQ_W'(pick.idx);

    // Pointer advances past the winner, wrapping at NUM_REQ-1.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rr_ptr <= '0;
        end else if (upd_en && gnt_vld) begin
            rr_ptr <= (gnt_idx == REQ_W'(NUM_REQ - 1)) ? '0 : gnt_idx + REQ_W'(1);
        end
    end

endmodule

// File: rtl/sha_mem_arbiter.sv
// Shares one single-port word SRAM among NUM_REQ hash cores. Grants are
// combinational and round-robin; read data returns one cycle after the
// grant with a one-hot rvalid naming the requester.
// Optional: define SHA_ARB_LOCK_EN to let a core hold the port for a burst
// by keeping req_lock high.
module sha_mem_arbiter
    import sha_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int REQ_W   = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    input  logic [NUM_REQ-1:0]        req_lock,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        rvalid,
    output logic [DATA_W-1:0]         rdata,
    output logic                      mem_clk,
    output logic                      mem_we,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_write_data,
    input  logic [DATA_W-1:0]         mem_read_data,
    output logic [31:0]               busy_cycles
);

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    logic               arb_vld;
    logic [REQ_W-1:0]   arb_idx;
    logic               upd_en;
    logic               win_vld;
    logic [REQ_W-1:0]   win_idx;
    mem_req_t           win_req;
    logic [ADDR_W-1:0]  held_addr;
    logic [DATA_W-1:0]  held_wdata;
    logic               rd_pending;
    logic [REQ_W-1:0]   rd_id;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .REQ_W   (REQ_W)
    ) u_rr (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req),
        .upd_en  (upd_en),
        .gnt_vld (arb_vld),
        .gnt_idx (arb_idx)
    );

`ifdef SHA_ARB_LOCK_EN
    logic             lock_vld;
    logic [REQ_W-1:0] lock_owner;
    logic             lock_active;

    // The lock only holds while its owner keeps both req and req_lock high;
    // on release the pointer already sits just past the owner.
    assign lock_active = lock_vld && req[lock_owner] && req_lock[lock_owner];
    assign win_vld     = lock_active ? 1'b1 : arb_vld;
    assign win_idx     = lock_active ? lock_owner : arb_idx;
    assign upd_en      = !lock_active;

    // Record the owner of any grant taken with req_lock asserted.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            lock_vld   <= 1'b0;
            lock_owner <= '0;
        end else if (win_vld) begin
            lock_vld   <= req_lock[win_idx];
            lock_owner <= win_idx;
        end else begin
            lock_vld   <= 1'b0;
        end
    end
`else
    logic unused_req_lock;

    assign unused_req_lock = ^req_lock;
    assign win_vld         = arb_vld;
    assign win_idx         = arb_idx;
    assign upd_en          = 1'b1;
`endif

    // Select the winning core's access fields.
    always_comb begin
        win_req.we    = req_we[win_idx];
        win_req.addr  = req_addr[int'(win_idx)*ADDR_W +: ADDR_W];
        win_req.wdata = req_wdata[int'(win_idx)*DATA_W +: DATA_W];
    end

    // Drive grant, memory port and read-return strobes; all quiet in reset.
    always_comb begin
        gnt            = '0;
        rvalid         = '0;
        mem_we         = 1'b0;
        mem_addr       = '0;
        mem_write_data = '0;
        if (reset_n) begin
            if (win_vld) begin
                gnt[win_idx]   = 1'b1;
                mem_we         = win_req.we;
                mem_addr       = win_req.addr;
                mem_write_data = win_req.wdata;
            end else begin
                mem_addr       = held_addr;
                mem_write_data = held_wdata;
            end
            if (rd_pending) begin
                rvalid[rd_id] = 1'b1;
            end
        end
    end

    assign rdata   = mem_read_data;
    assign mem_clk = clk;

    // Grant stage -> read-return stage; idle address/data hold last grant.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_pending  <= 1'b0;
            held_addr   <= '0;
            held_wdata  <= '0;
            busy_cycles <= '0;
        end else begin
            rd_pending <= win_vld && !win_req.we;
            if (win_vld) begin
                held_addr   <= win_req.addr;
                held_wdata  <= win_req.wdata;
                busy_cycles <= sat_inc(busy_cycles);
            end
        end
    end

    // Requester tag for the read in flight; only meaningful with rd_pending.
    always_ff @(posedge clk) begin
        if (win_vld) begin
            rd_id <= win_idx;
        end
    end

endmodule

// File: tb/tb_sha_mem_arbiter.sv
// Self-checking bench for sha_mem_arbiter: directed scenarios plus a
// randomized run checked against a cycle-level behavioural model.
module tb_sha_mem_arbiter;

    localparam int N = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [N-1:0]  req, req_we, req_lock;
    logic [N*16-1:0] req_addr;
    logic [N*32-1:0] req_wdata;
    logic [N-1:0]  gnt, rvalid;
    logic [31:0]   rdata;
    logic          mem_clk, mem_we;
    logic [15:0]   mem_addr;
    logic [31:0]   mem_write_data, mem_read_data;
    logic [31:0]   busy_cycles;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    sha_mem_arbiter #(.NUM_REQ(N)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .req            (req),
        .req_we         (req_we),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .req_lock       (req_lock),
        .gnt            (gnt),
        .rvalid         (rvalid),
        .rdata          (rdata),
        .mem_clk        (mem_clk),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data),
        .busy_cycles    (busy_cycles)
    );

    // SRAM behind the port, with a preload path used only during reset.
    logic [31:0] sram [0:1023];
    logic        pre_we = 1'b0;
    logic [9:0]  pre_addr;
    logic [31:0] pre_data;

    always @(posedge clk) begin
        if (pre_we) sram[pre_addr] <= pre_data;
        else if (mem_we) sram[mem_addr[9:0]] <= mem_write_data;
        mem_read_data <= sram[mem_addr[9:0]];
    end

    // Reference model state.
    logic [31:0] shadow [0:1023];
    int          m_ptr, m_rd_id, m_lock_owner;
    bit          m_pend, m_lock_vld;
    logic [31:0] m_rd_data, m_busy, m_hdata;
    logic [15:0] m_haddr;

    logic [N-1:0] e_gnt, e_rvalid;
    logic         e_we;
    logic [15:0]  e_addr;
    logic [31:0]  e_wdata, e_rdata;
    int           e_win;

    task automatic model_eval();
        e_gnt = '0; e_rvalid = '0; e_we = 1'b0; e_addr = '0; e_wdata = '0;
        e_rdata = m_rd_data; e_win = -1;
        if (reset_n) begin
            if (m_pend) e_rvalid[m_rd_id] = 1'b1;
`ifdef SHA_ARB_LOCK_EN
            if (m_lock_vld && req[m_lock_owner] && req_lock[m_lock_owner]) e_win = m_lock_owner;
`endif
            if (e_win < 0) begin
                for (int k = 0; k < N; k++) begin
                    int c;
                    c = (m_ptr + k) % N;
                    if (e_win < 0 && req[c]) e_win = c;
                end
            end
            if (e_win >= 0) begin
                e_gnt[e_win] = 1'b1;
                e_we    = req_we[e_win];
                e_addr  = req_addr[e_win*16 +: 16];
                e_wdata = req_wdata[e_win*32 +: 32];
            end else begin
                e_addr  = m_haddr;
                e_wdata = m_hdata;
            end
        end
    endtask

    // Advance the model by one clock with the current inputs, then the DUT.
    task automatic tick();
        bit locked;
        if (!reset_n) begin
            m_ptr = 0; m_pend = 0; m_rd_id = 0; m_busy = 0;
            m_lock_vld = 0; m_lock_owner = 0; m_haddr = 0; m_hdata = 0;
        end else begin
            model_eval();
            locked = 0;
`ifdef SHA_ARB_LOCK_EN
            locked = m_lock_vld && req[m_lock_owner] && req_lock[m_lock_owner];
            m_lock_vld = 0;
`endif
            m_pend = 0;
            if (e_win >= 0) begin
                if (!locked) m_ptr = (e_win + 1) % N;
`ifdef SHA_ARB_LOCK_EN
                m_lock_vld = req_lock[e_win];
                m_lock_owner = e_win;
`endif
                if (e_we) shadow[e_addr[9:0]] = e_wdata;
                else begin
                    m_pend = 1; m_rd_id = e_win; m_rd_data = shadow[e_addr[9:0]];
                end
                m_haddr = e_addr; m_hdata = e_wdata;
                if (m_busy != 32'hFFFF_FFFF) m_busy = m_busy + 1;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic set_core(input int i, input logic we, input logic [15:0] a, input logic [31:0] d);
        req_we[i] = we;
        req_addr[i*16 +: 16] = a;
        req_wdata[i*32 +: 32] = d;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; req = '0; req_we = '0; req_lock = '0; req_addr = '0; req_wdata = '0;
        for (int i = 0; i < 1024; i++) begin
            pre_we = 1'b1; pre_addr = 10'(i);
            pre_data = (i == 5) ? 32'hDEADBEEF : $urandom;
            shadow[i] = pre_data;
            @(posedge clk); #1;
        end
        pre_we = 1'b0;
        tick();
        for (int c = 0; c < 3; c++) begin
            req = 4'($urandom_range(1, 15)); req_we = 4'($urandom);
            req_addr = {$urandom, $urandom}; req_wdata = {$urandom, $urandom, $urandom, $urandom};
            #3;
            n_chk++; if (gnt !== 4'b0) begin n_fail++; $display("FAIL reset_gnt: got %b expected 0000", gnt); end
            n_chk++; if (rvalid !== 4'b0) begin n_fail++; $display("FAIL reset_rvalid: got %b expected 0000", rvalid); end
            n_chk++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we: got %b expected 0", mem_we); end
            n_chk++; if (mem_addr !== 16'h0) begin n_fail++; $display("FAIL reset_mem_addr: got %h expected 0000", mem_addr); end
            n_chk++; if (mem_write_data !== 32'h0) begin n_fail++; $display("FAIL reset_wdata: got %h expected 0", mem_write_data); end
            n_chk++; if (busy_cycles !== 32'h0) begin n_fail++; $display("FAIL reset_busy: got %0d expected 0", busy_cycles); end
            tick();
        end
        req = '0;
    endtask

    task automatic test_single_read();
        reset_n = 1'b1; req = 4'b0001; set_core(0, 1'b0, 16'd5, 32'h0);
        #3;
        n_chk++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL single_gnt: got %b expected 0001", gnt); end
        n_chk++; if (mem_addr !== 16'd5) begin n_fail++; $display("FAIL single_addr: got %0d expected 5", mem_addr); end
        tick();
        req = '0; #3;
        n_chk++; if (rvalid !== 4'b0001) begin n_fail++; $display("FAIL single_rvalid: got %b expected 0001", rvalid); end
        n_chk++; if (rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_rdata: got %h expected deadbeef", rdata); end
        n_chk++; if (busy_cycles !== 32'd1) begin n_fail++; $display("FAIL single_busy: got %0d expected 1", busy_cycles); end
        tick();
    endtask

    task automatic test_rotation();
        int cnt [N];
        logic [N-1:0] exp;
        for (int i = 0; i < N; i++) cnt[i] = 0;
        reset_n = 1'b0; req = '0; tick(); reset_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            req = 4'hF;
            for (int i = 0; i < N; i++) set_core(i, 1'b0, 16'($urandom_range(0, 1023)), 32'h0);
            #3;
            model_eval();
            exp = 4'b0001 << (c % 4);
            n_chk++; if (gnt !== exp) begin n_fail++; $display("FAIL rot_gnt c%0d: got %b expected %b", c, gnt, exp); end
            if (c > 0) begin
                exp = 4'b0001 << ((c - 1) % 4);
                n_chk++; if (rvalid !== exp) begin n_fail++; $display("FAIL rot_rvalid c%0d: got %b expected %b", c, rvalid, exp); end
                n_chk++; if (rdata !== e_rdata) begin n_fail++; $display("FAIL rot_rdata c%0d: got %h expected %h", c, rdata, e_rdata); end
            end
            for (int i = 0; i < N; i++) if (gnt[i]) cnt[i]++;
            tick();
        end
        req = '0; #3;
        n_chk++; if (busy_cycles !== 32'd8) begin n_fail++; $display("FAIL rot_busy: got %0d expected 8", busy_cycles); end
        for (int i = 0; i < N; i++) begin
            n_chk++; if (cnt[i] != 2) begin n_fail++; $display("FAIL rot_count core%0d: got %0d expected 2", i, cnt[i]); end
        end
        tick();
    endtask

    task automatic test_interleaved();
        req = 4'b0010; set_core(1, 1'b1, 16'd1000, 32'h01234765);
        #3;
        n_chk++; if (gnt !== 4'b0010) begin n_fail++; $display("FAIL inter_wgnt: got %b expected 0010", gnt); end
        n_chk++; if ({mem_we, mem_addr, mem_write_data} !== {1'b1, 16'd1000, 32'h01234765}) begin
            n_fail++; $display("FAIL inter_wport: got we=%b a=%0d d=%h expected we=1 a=1000 d=01234765", mem_we, mem_addr, mem_write_data); end
        tick();
        req = 4'b0100; set_core(2, 1'b0, 16'd1000, 32'h0); #3;
        n_chk++; if (gnt !== 4'b0100 || mem_we !== 1'b0) begin n_fail++; $display("FAIL inter_rgnt: got %b we=%b expected 0100 we=0", gnt, mem_we); end
        n_chk++; if (rvalid !== 4'b0000) begin n_fail++; $display("FAIL inter_wr_rvalid: got %b expected 0000", rvalid); end
        tick();
        req = '0; #3;
        n_chk++; if (rvalid !== 4'b0100) begin n_fail++; $display("FAIL inter_rvalid: got %b expected 0100", rvalid); end
        n_chk++; if (rdata !== 32'h01234765) begin n_fail++; $display("FAIL inter_rdata: got %h expected 01234765", rdata); end
        tick();
    endtask

    task automatic test_back_to_back();
        req = 4'b1001; set_core(3, 1'b0, 16'd20, 32'h0); set_core(0, 1'b0, 16'd21, 32'h0);
        #3;
        n_chk++; if (gnt !== 4'b1000) begin n_fail++; $display("FAIL b2b_gnt3: got %b expected 1000", gnt); end
        tick();
        req = 4'b0001; #3;
        n_chk++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL b2b_gnt0: got %b expected 0001", gnt); end
        n_chk++; if (rvalid !== 4'b1000 || rdata !== shadow[20]) begin
            n_fail++; $display("FAIL b2b_rd3: got %b/%h expected 1000/%h", rvalid, rdata, shadow[20]); end
        tick();
        req = '0; #3;
        n_chk++; if (rvalid !== 4'b0001 || rdata !== shadow[21]) begin
            n_fail++; $display("FAIL b2b_rd0: got %b/%h expected 0001/%h", rvalid, rdata, shadow[21]); end
        tick();
    endtask

`ifdef SHA_ARB_LOCK_EN
    task automatic test_lock();
        req_lock = 4'b0010; req = 4'b0010;
        set_core(1, 1'b0, 16'd40, 32'h0); set_core(0, 1'b0, 16'd41, 32'h0); set_core(2, 1'b0, 16'd42, 32'h0);
        for (int c = 0; c < 16; c++) begin
            #3;
            n_chk++; if (gnt !== 4'b0010) begin n_fail++; $display("FAIL lock_gnt c%0d: got %b expected 0010", c, gnt); end
            tick();
            req = 4'b0111; set_core(1, 1'b0, 16'(40 + c), 32'h0);
        end
        req = 4'b0101; req_lock = '0; #3;
        n_chk++; if (gnt !== 4'b0100) begin n_fail++; $display("FAIL lock_release: got %b expected 0100", gnt); end
        tick();
        req = '0; tick();
    endtask
`endif

    task automatic test_reset_midread();
        req = 4'b0010; req_lock = '0; set_core(1, 1'b0, 16'd7, 32'h0); #3;
        n_chk++; if (gnt !== 4'b0010) begin n_fail++; $display("FAIL rmid_gnt: got %b expected 0010", gnt); end
        tick();
        reset_n = 1'b0; req = 4'b1111; #3;
        n_chk++; if (rvalid !== 4'b0 || gnt !== 4'b0) begin n_fail++; $display("FAIL rmid_quiet: got rv=%b g=%b expected 0/0", rvalid, gnt); end
        tick(); #3;
        n_chk++; if (rvalid !== 4'b0 || mem_addr !== 16'h0 || busy_cycles !== 32'h0) begin
            n_fail++; $display("FAIL rmid_state: got rv=%b a=%h busy=%0d expected 0", rvalid, mem_addr, busy_cycles); end
        tick();
        reset_n = 1'b1; #3;
        n_chk++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL rmid_first: got %b expected 0001", gnt); end
        n_chk++; if (rvalid !== 4'b0) begin n_fail++; $display("FAIL rmid_norv: got %b expected 0000", rvalid); end
        tick();
        req = '0; tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            req = 4'($urandom); req_we = 4'($urandom);
            req_lock = 4'($urandom) & 4'($urandom);
            for (int i = 0; i < N; i++) begin
                req_addr[i*16 +: 16] = 16'($urandom_range(0, 1023));
                req_wdata[i*32 +: 32] = $urandom;
            end
            #3;
            model_eval();
            n_chk++; if (gnt !== e_gnt) begin n_fail++; $display("FAIL rand_gnt c%0d: got %b expected %b", c, gnt, e_gnt); end
            n_chk++; if (mem_we !== e_we) begin n_fail++; $display("FAIL rand_we c%0d: got %b expected %b", c, mem_we, e_we); end
            n_chk++; if (mem_addr !== e_addr) begin n_fail++; $display("FAIL rand_addr c%0d: got %h expected %h", c, mem_addr, e_addr); end
            n_chk++; if (mem_write_data !== e_wdata) begin n_fail++; $display("FAIL rand_wdata c%0d: got %h expected %h", c, mem_write_data, e_wdata); end
            n_chk++; if (rvalid !== e_rvalid) begin n_fail++; $display("FAIL rand_rvalid c%0d: got %b expected %b", c, rvalid, e_rvalid); end
            if (e_rvalid != 0) begin
                n_chk++; if (rdata !== e_rdata) begin n_fail++; $display("FAIL rand_rdata c%0d: got %h expected %h", c, rdata, e_rdata); end
            end
            n_chk++; if (busy_cycles !== m_busy) begin n_fail++; $display("FAIL rand_busy c%0d: got %0d expected %0d", c, busy_cycles, m_busy); end
            tick();
        end
        req = '0; req_lock = '0; tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_read();
        test_rotation();
        test_interleaved();
        test_back_to_back();
`ifdef SHA_ARB_LOCK_EN
        test_lock();
`endif
        test_reset_midread();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
